seq_detect_frame_ctrl: RTL
==========================

// Module: seq_detect_frame_ctrl
// PURPOSE
//  Frame-level controller for the serial "1101" Mealy detector. Accepts DATA_W-bit words over valid/ready
//  and serializes them MSB-first into the detector through a bit-enable. It counts detector hits per frame,
//  records the bit position of the last hit, and signals frame completion.
//  Sits between the word-wide source and a clock-enabled detector instance (state advances only when det_en=1).
// PARAMETERS
//  DATA_W  8  bits per input word
//  LEN_W   8  width of frame_len (words per frame)
//  CNT_W   8  width of saturating hit counter
//  POS_W   = LEN_W+$clog2(DATA_W) (derived, not overridable): width of bit index within frame
// PORTS
//  clk           in   1       single clock, all flops rising edge
//  rst_n         in   1       asynchronous active-low reset
//  start         in   1       begin frame; sampled only in IDLE
//  abort         in   1       sync abort; honoured in any state except IDLE
//  frame_len     in   LEN_W   words in frame; latched on accepted start
//  s_valid       in   1       input word valid
//  s_data        in   DATA_W  input word, bit DATA_W-1 sent first
//  s_ready       out  1       controller can take a word
//  det_clr       out  1       registered 1-cycle clear to detector (state->00)
//  det_en        out  1       detector advances this cycle
//  det_in        out  1       serial bit to detector
//  det_hit       in   1       detector Mealy output; valid when det_en=1
//  busy          out  1       frame in progress (state != IDLE)
//  done          out  1       1-cycle pulse, frame completed normally
//  hit_cnt       out  CNT_W   hits in current/last frame, saturating
//  sat           out  1       hit_cnt saturated this frame
//  last_hit_pos  out  POS_W   0-based frame bit index of latest hit
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (s_ready, det_clr, det_en, det_in, busy, done, hit_cnt, sat, last_hit_pos).
//  FSM states: IDLE, CLR, LOAD, SHIFT, DONE.
//  IDLE: start=1 -> latch frame_len; clear hit_cnt/sat/last_hit_pos/bit_idx. frame_len=0 -> DONE, else -> CLR.
//   start in any other state is ignored.
//  CLR: det_clr=1 for exactly this cycle (flop-driven) -> LOAD. s_ready=0, det_en=0.
//  LOAD: s_ready=1. s_valid&s_ready -> shreg<=s_data, bits_left<=DATA_W-1, words_left-- -> SHIFT.
//   Stall is unbounded; det_en=0 while in LOAD.
//  SHIFT: det_en=1, det_in=shreg[DATA_W-1]; shift left 1 each cycle; bit_idx++.
//   bits_left!=0: stay, bits_left--.
//   bits_left==0 & words_left!=0: s_ready=1. s_valid=1 -> reload shreg, stay in SHIFT (zero bubble);
//    s_valid=0 -> LOAD.
//   bits_left==0 & words_left==0: -> DONE.
//  DONE: done=1 for one cycle -> IDLE. busy falls the cycle after done.
//  Hit accounting: a hit is counted when det_en&det_hit in the same cycle.
//   On a hit: hit_cnt++ unless all-ones, which sets sat=1 instead; last_hit_pos<=bit_idx (current bit).
//  Results hold in IDLE until the next accepted start.
//  abort=1 in CLR/LOAD/SHIFT/DONE -> IDLE next cycle; no done; det_clr pulses 1 cycle; counters hold.
//   abort has priority over every transition.
//  s_ready never asserts outside LOAD or the last-bit cycle of SHIFT; no word is accepted after the last word.
//  Width rules: bit_idx is POS_W bits and cannot overflow (max frame bits = 2^LEN_W-1 words * DATA_W).
//  rst_n low mid-frame: immediate return to reset values; partial frame is discarded.
// TESTING
//  T1 frame_len=1, s_data=8'hDA (11011010) -> det_en high 8 cycles; hit_cnt=2, last_hit_pos=6, done pulse.
//  T2 frame_len=2, words 8'h01,8'hA0, s_valid held -> no det_en gap; hit_cnt=1 (spans words), last_hit_pos=10.
//  T3 T2 with s_valid low 3 cycles between words -> det_en low 3 cycles; s_ready=1 throughout the stall;
//     hit_cnt=1, last_hit_pos=10.
//  T4 CNT_W=2, frame_len=4, all words 8'hDB -> hit_cnt=3, sat=1.
//  T5 frame_len=0 -> done 1 cycle after start is sampled; s_ready, det_en, det_clr never high; hit_cnt=0.
//  T6 abort in 3rd SHIFT cycle -> IDLE next cycle, det_clr 1-cycle pulse, no done. rst_n low mid-frame ->
//     all outputs 0. A following T1 frame passes.

Source files
------------

// File: rtl/seq_detect_frame_ctrl.sv
// Frame controller for a serial "1101" detector: takes words over valid/ready, feeds them MSB-first
// through det_en/det_in, and tallies detector hits (saturating count, last hit bit index) per frame.
module seq_detect_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 8,
    localparam int POS_W = LEN_W + $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              det_clr,
    output logic              det_en,
    output logic              det_in,
    input  logic              det_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              sat,
    output logic [POS_W-1:0]  last_hit_pos
);

    localparam int BL_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BL_W-1:0]  BITS_LAST = BL_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    logic [BL_W-1:0]   bits_left_r;
    logic [LEN_W-1:0]  words_left_r;
    logic [DATA_W-1:0] shreg_r;
    logic [POS_W-1:0]  bit_idx_r;
    logic              hit_s;
    logic [LEN_W-1:0]  words_dec_s;

    assign det_in      = shreg_r[DATA_W-1];
    assign hit_s       = det_en & det_hit;
    assign words_dec_s = words_left_r - LEN_W'(1);

    // Frame FSM; every output except det_in is a flop updated together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bits_left_r  <= '0;
            words_left_r <= '0;
            shreg_r      <= '0;
            bit_idx_r    <= '0;
            s_ready      <= 1'b0;
            det_clr      <= 1'b0;
            det_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            hit_cnt      <= '0;
            sat          <= 1'b0;
            last_hit_pos <= '0;
        end else begin
            det_clr <= 1'b0;
            done    <= 1'b0;
            if (abort && (state_r != ST_IDLE)) begin
                // Drop the frame but leave the results of the bits already seen in place.
                state_r <= ST_IDLE;
                det_clr <= 1'b1;
                det_en  <= 1'b0;
                s_ready <= 1'b0;
                busy    <= 1'b0;
                shreg_r <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            words_left_r <= frame_len;
                            hit_cnt      <= '0;
                            sat          <= 1'b0;
                            last_hit_pos <= '0;
                            bit_idx_r    <= '0;
                            busy         <= 1'b1;
                            if (frame_len == '0) begin
                                state_r <= ST_DONE;
                                done    <= 1'b1;
                            end else begin
                                state_r <= ST_CLR;
                                det_clr <= 1'b1;
                            end
                        end
                    end
                    ST_CLR: begin
                        state_r <= ST_LOAD;
                        s_ready <= 1'b1;
                    end
                    ST_LOAD: begin
                        if (s_valid) begin
                            shreg_r      <= s_data;
                            bits_left_r  <= BITS_LAST;
                            words_left_r <= words_dec_s;
                            state_r      <= ST_SHIFT;
                            det_en       <= 1'b1;
                            s_ready      <= (BITS_LAST == '0) && (words_dec_s != '0);
                        end
                    end
                    ST_SHIFT: begin
                        shreg_r   <= shreg_r << 1;
                        bit_idx_r <= bit_idx_r + POS_W'(1);
                        if (hit_s) begin
                            if (hit_cnt == CNT_MAX) begin
                                sat <= 1'b1;
                            end else begin
                                hit_cnt <= hit_cnt + CNT_W'(1);
                            end
                            last_hit_pos <= bit_idx_r;
                        end
                        if (bits_left_r != '0) begin
                            bits_left_r <= bits_left_r - BL_W'(1);
                            // Open the input one cycle early so the next word lands without a bubble.
                            s_ready     <= (bits_left_r == BL_W'(1)) && (words_left_r != '0);
                        end else if (words_left_r != '0) begin
                            if (s_valid) begin
                                shreg_r      <= s_data;
                                bits_left_r  <= BITS_LAST;
                                words_left_r <= words_dec_s;
                                s_ready      <= (BITS_LAST == '0) && (words_dec_s != '0);
                            end else begin
                                state_r <= ST_LOAD;
                                det_en  <= 1'b0;
                                s_ready <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_DONE;
                            det_en  <= 1'b0;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        det_en  <= 1'b0;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
